// File: rtl/rs_addsub.sv
// Reservation station in front of the add/sub FU: holds issued ops until both
// operands resolve (direct, issue-time bypass or CDB snoop), dispatches one per cycle.
module rs_addsub_entry #(
  parameter int DW = 12,
  parameter int LW = 2
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          wr,
  input  logic          clr,
  input  logic [2:0]    op_in,
  input  logic [LW-1:0] label_in,
  input  logic [DW-1:0] vj_in,
  input  logic          qj_pend_in,
  input  logic [LW-1:0] qj_in,
  input  logic [DW-1:0] vk_in,
  input  logic          qk_pend_in,
  input  logic [LW-1:0] qk_in,
  input  logic          cdb_valid,
  input  logic [LW-1:0] cdb_label,
  input  logic [DW-1:0] cdb_data,
  output logic          busy,
  output logic          ready,
  output logic [2:0]    op,
  output logic [LW-1:0] label,
  output logic [DW-1:0] vj,
  output logic [DW-1:0] vk
);
  logic          qj_pend, qk_pend;
  logic [LW-1:0] qj, qk;
  logic          wake_j, wake_k;

  assign wake_j = busy & cdb_valid & qj_pend & (qj == cdb_label);
  assign wake_k = busy & cdb_valid & qk_pend & (qk == cdb_label);
  assign ready  = busy & ~qj_pend & ~qk_pend;

  // wr only targets a free entry and clr only a busy one, so they never collide
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      busy <= 1'b0; op <= '0; label <= '0;
      vj <= '0; qj_pend <= 1'b0; qj <= '0;
      vk <= '0; qk_pend <= 1'b0; qk <= '0;
    end else if (wr) begin
      busy <= 1'b1; op <= op_in; label <= label_in;
      vj <= vj_in; qj_pend <= qj_pend_in; qj <= qj_in;
      vk <= vk_in; qk_pend <= qk_pend_in; qk <= qk_in;
    end else begin
      if (clr) busy <= 1'b0;
      if (wake_j) begin vj <= cdb_data; qj_pend <= 1'b0; end
      if (wake_k) begin vk <= cdb_data; qk_pend <= 1'b0; end
    end
  end
endmodule

module rs_addsub #(
  parameter int DEPTH = 2,
  parameter int DW    = 12,
  parameter int LW    = 2
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          iss_valid,
  input  logic [2:0]    iss_op,
  input  logic [LW-1:0] iss_label,
  input  logic [DW-1:0] iss_vj,
  input  logic          iss_qj_pend,
  input  logic [LW-1:0] iss_qj,
  input  logic [DW-1:0] iss_vk,
  input  logic          iss_qk_pend,
  input  logic [LW-1:0] iss_qk,
  output logic          iss_accept,
  output logic          iss_err,
  output logic          rs_full,
  input  logic          cdb_valid,
  input  logic [LW-1:0] cdb_label,
  input  logic [DW-1:0] cdb_data,
  output logic          fu_en,
  output logic [DW-1:0] fu_rx,
  output logic [DW-1:0] fu_ry,
  output logic [2:0]    fu_op,
  output logic [LW-1:0] fu_label,
  input  logic          fu_done
);
  logic [DEPTH-1:0]          busy, ready, wr_oh, sel_oh;
  logic [DEPTH-1:0][2:0]     op_a;
  logic [DEPTH-1:0][LW-1:0]  label_a;
  logic [DEPTH-1:0][DW-1:0]  vj_a, vk_a;
  logic                      legal, fu_busy, dispatch, byp_j, byp_k, found_w, found_s;
  logic [DW-1:0]             vj_in, vk_in, d_rx, d_ry;
  logic [2:0]                d_op;
  logic [LW-1:0]             d_label;

  assign legal      = (iss_op == 3'b000) | (iss_op == 3'b001);
  assign rs_full    = &busy;
  assign iss_accept = iss_valid & ~rs_full & legal;

  // Same-cycle CDB result resolves the operand before it is stored
  assign byp_j = iss_qj_pend & cdb_valid & (iss_qj == cdb_label);
  assign byp_k = iss_qk_pend & cdb_valid & (iss_qk == cdb_label);
  assign vj_in = byp_j ? cdb_data : iss_vj;
  assign vk_in = byp_k ? cdb_data : iss_vk;

  always_comb begin
    wr_oh   = '0;
    sel_oh  = '0;
    found_w = 1'b0;
    found_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!busy[i] && !found_w) begin wr_oh[i] = iss_accept; found_w = 1'b1; end
      if (ready[i] && !found_s) begin sel_oh[i] = 1'b1; found_s = 1'b1; end
    end
  end

  assign dispatch = (~fu_busy | fu_done) & (|ready);

  always_comb begin
    d_rx = '0; d_ry = '0; d_op = '0; d_label = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel_oh[i]) begin
        d_rx = d_rx | vj_a[i]; d_ry = d_ry | vk_a[i];
        d_op = d_op | op_a[i]; d_label = d_label | label_a[i];
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    rs_addsub_entry #(.DW(DW), .LW(LW)) u_ent (
      .Clock(Clock), .Resetn(Resetn),
      .wr(wr_oh[g]), .clr(sel_oh[g] & dispatch),
      .op_in(iss_op), .label_in(iss_label),
      .vj_in(vj_in), .qj_pend_in(iss_qj_pend & ~byp_j), .qj_in(iss_qj),
      .vk_in(vk_in), .qk_pend_in(iss_qk_pend & ~byp_k), .qk_in(iss_qk),
      .cdb_valid(cdb_valid), .cdb_label(cdb_label), .cdb_data(cdb_data),
      .busy(busy[g]), .ready(ready[g]), .op(op_a[g]), .label(label_a[g]),
      .vj(vj_a[g]), .vk(vk_a[g])
    );
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      fu_en <= 1'b0; fu_rx <= '0; fu_ry <= '0; fu_op <= '0; fu_label <= '0;
      fu_busy <= 1'b0; iss_err <= 1'b0;
    end else begin
      fu_en   <= dispatch;
      iss_err <= iss_valid & ~legal;
      if (dispatch) begin
        fu_rx <= d_rx; fu_ry <= d_ry; fu_op <= d_op; fu_label <= d_label;
        fu_busy <= 1'b1;
      end else if (fu_done) begin
        fu_busy <= 1'b0;
      end
    end
  end
endmodule
